// File: rtl/alu_hist_pkg.sv
// Shared definitions for the ALU result history: capture FSM encoding, default data width
// and the active-low 7-segment digit table (bit0 = segment a).
package alu_hist_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  localparam int unsigned DataWDefault = 8;

  // Indexed by hex digit value; element 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] Seg7Table = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low 7-segment pattern (bit0 = segment a), purely combinational.
module seg7_decode
  import alu_hist_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = Seg7Table[digit_i];

endmodule

// File: rtl/alu_result_history.sv
// Circular history of ALU results captured once per key press, with recall stepping.
// Define ALU_HISTORY_SEVENSEG_EN to add HEX_LO/HEX_HI decoders of the shown entry.
module alu_result_history
  import alu_hist_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              recall,
  input  logic              clear,
  output logic [DATA_W-1:0] current,
  output logic [DATA_W-1:0] shown,
  output logic [PTR_W-1:0]  shown_idx,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
`ifdef ALU_HISTORY_SEVENSEG_EN
  ,
  output logic [6:0]        HEX_LO,
  output logic [6:0]        HEX_HI
`endif
);

  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [PTR_W-1:0]    shown_idx_q, shown_idx_d;
  logic                accept;
  logic [PTR_W:0]      shown_idx_ext;
  logic [PTR_W-1:0]    newest_ptr, shown_ptr;

  assign shown_idx_ext = {1'b0, shown_idx_q};
  assign full          = (count_q == DepthCnt);
  assign empty         = (count_q == '0);

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    shown_idx_d = shown_idx_q;
    accept      = 1'b0;
    if (clear) begin
      // Data is left in place; count masks it from the outputs.
      count_d     = '0;
      wr_ptr_d    = '0;
      shown_idx_d = '0;
      state_d     = in_valid ? StHold : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            accept  = 1'b1;
            state_d = StHold;
          end
        end
        StHold: begin
          if (!in_valid) state_d = StIdle;
        end
      endcase
      if (accept) begin
        mem_d[wr_ptr_q] = alu_result;
        wr_ptr_d        = wr_ptr_q + 1'b1;
        if (!full) count_d = count_q + 1'b1;
        shown_idx_d     = '0;
      end else if (recall && !empty) begin
        shown_idx_d = (shown_idx_ext == count_q - 1'b1) ? '0 : shown_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q     <= StIdle;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      count_q     <= '0;
      shown_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      shown_idx_q <= shown_idx_d;
    end
  end

  // DEPTH is a power of two, so PTR_W-bit wraparound gives the modulo.
  assign newest_ptr = wr_ptr_q - 1'b1;
  assign shown_ptr  = wr_ptr_q - 1'b1 - shown_idx_q;

  assign in_ready  = (state_q == StIdle);
  assign current   = empty ? '0 : mem_q[newest_ptr];
  assign shown     = empty ? '0 : mem_q[shown_ptr];
  assign shown_idx = shown_idx_q;
  assign count     = count_q;

`ifdef ALU_HISTORY_SEVENSEG_EN
  seg7_decode u_seg_lo (
    .digit_i (shown[3:0]),
    .seg_o   (HEX_LO)
  );

  seg7_decode u_seg_hi (
    .digit_i (shown[7:4]),
    .seg_o   (HEX_HI)
  );
`endif

endmodule

// File: tb/tb_alu_result_history.sv
// Scoreboard bench for alu_result_history: a queue-based history model predicts outputs per cycle.
module tb_alu_result_history;

  localparam int unsigned Depth = 4;

  typedef struct packed {
    logic [7:0] current;
    logic [7:0] shown;
    logic [1:0] idx;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       in_ready;
  } obs_t;

  logic       Clock = 1'b1;
  logic       Reset_b = 1'b0;
  logic [7:0] alu_result = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       recall = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] current;
  logic [7:0] shown;
  logic [1:0] shown_idx;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef ALU_HISTORY_SEVENSEG_EN
  logic [6:0] HEX_LO;
  logic [6:0] HEX_HI;
`endif

  alu_result_history dut (
    .Clock      (Clock),
    .Reset_b    (Reset_b),
    .alu_result (alu_result),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .recall     (recall),
    .clear      (clear),
    .current    (current),
    .shown      (shown),
    .shown_idx  (shown_idx),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef ALU_HISTORY_SEVENSEG_EN
    ,
    .HEX_LO     (HEX_LO),
    .HEX_HI     (HEX_HI)
`endif
  );

  always #5 Clock = ~Clock;

  // Reference model: newest entry at index 0, key-held flag, recall age.
  logic [7:0] hist[$];
  bit         held;
  int         age;
  obs_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.count    = 3'(hist.size());
    o.current  = (hist.size() > 0) ? hist[0] : 8'h00;
    o.shown    = (hist.size() > 0) ? hist[age] : 8'h00;
    o.idx      = 2'(age);
    o.full     = (hist.size() == Depth);
    o.empty    = (hist.size() == 0);
    o.in_ready = !held;
    return o;
  endfunction

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    held = 1'b0;
    age  = 0;
  endtask

  task automatic model_update(input bit v, input logic [7:0] a, input bit r, input bit c);
    if (c) begin
      hist.delete();
      age  = 0;
      held = v;
    end else if (!held && v) begin
      hist.push_front(a);
      if (hist.size() > Depth) void'(hist.pop_back());
      age  = 0;
      held = 1'b1;
    end else begin
      if (held && !v) held = 1'b0;
      if (r && hist.size() > 0) age = (age + 1) % hist.size();
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.current  = current;
    o.shown    = shown;
    o.idx      = shown_idx;
    o.count    = count;
    o.full     = full;
    o.empty    = empty;
    o.in_ready = in_ready;
    return o;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t a;
    bit   bad;
    a = dut_obs();
    vectors++;
    bad = (a !== e);
`ifdef ALU_HISTORY_SEVENSEG_EN
    if (HEX_LO !== seg_ref(e.shown[3:0]) || HEX_HI !== seg_ref(e.shown[7:4])) begin
      bad = 1'b1;
      $display("FAIL %s hex: got lo=%b hi=%b want lo=%b hi=%b", name, HEX_LO, HEX_HI,
               seg_ref(e.shown[3:0]), seg_ref(e.shown[7:4]));
    end
`endif
    if (a !== e) begin
      $display("FAIL %s @%0t: got cur=%h shown=%h idx=%0d cnt=%0d full=%b empty=%b rdy=%b want cur=%h shown=%h idx=%0d cnt=%0d full=%b empty=%b rdy=%b",
               name, $time, a.current, a.shown, a.idx, a.count, a.full, a.empty, a.in_ready,
               e.current, e.shown, e.idx, e.count, e.full, e.empty, e.in_ready);
    end
    if (bad) miscompares++;
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) check("cycle", exp_q.pop_front());
  end

  task automatic step(input bit v, input logic [7:0] a, input bit r, input bit c);
    in_valid   = v;
    alu_result = a;
    recall     = r;
    clear      = c;
    @(posedge Clock);
    model_update(v, a, r, c);
    exp_q.push_back(model_obs());
    #1;
  endtask

  task automatic press(input logic [7:0] a);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bit v_r;
    model_reset();
    exp_q.push_back(model_obs());
    #7 Reset_b = 1'b1;

    // Held key captures once.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill past depth, then walk back through history.
    for (int i = 1; i <= 5; i++) press(8'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Capture wins over recall.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hA7, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Clear while key held: no capture until release and re-press.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    press(8'h11); press(8'h22);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    press(8'h77);

    // Asynchronous reset while in HOLD with two entries.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    press(8'h12);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    @(negedge Clock);
    #1 Reset_b = 1'b0;
    model_reset();
    #1 check("async_reset", model_obs());
    #1 Reset_b = 1'b1;
    step(1'b1, 8'h5E, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic.
    v_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) v_r = !v_r;
      step(v_r, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    @(negedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
